// File: rtl/vpll_reconfig_ctrl.sv
// Video PLL retuning sequencer: writes N/M/C0 into an Altera PLL reconfig core
// over Avalon-MM (polling mode), waits for completion, then for a stable lock.
module vpll_reconfig_ctrl #(
    parameter int unsigned POLL_MAX     = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned LOCK_STABLE  = 256
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int unsigned PW = $clog2(POLL_MAX) + 1;
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned SW = $clog2(LOCK_STABLE) + 1;

    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);
    localparam logic [TW-1:0] TO_LIM   = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] STAB_LIM = SW'(LOCK_STABLE);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_MODE      = 4'd1;
    localparam logic [3:0] S_WR_N      = 4'd2;
    localparam logic [3:0] S_WR_M      = 4'd3;
    localparam logic [3:0] S_WR_C      = 4'd4;
    localparam logic [3:0] S_START     = 4'd5;
    localparam logic [3:0] S_POLL      = 4'd6;
    localparam logic [3:0] S_LOCK_WAIT = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;

    logic [3:0]    state;
    logic [17:0]   n_q;
    logic [17:0]   m_q;
    logic [17:0]   c0_q;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] stab_cnt;
    logic          lk_meta;
    logic          lk_s;

    logic          wr_ack;
    logic          rd_ack;
    logic [PW-1:0] poll_inc;
    logic [TW-1:0] to_inc;
    logic [SW-1:0] stab_inc;
    logic          unused_rd;

    assign unused_rd = ^mgmt_readdata[31:1];

    assign wr_ack = mgmt_write & ~mgmt_waitrequest;
    assign rd_ack = mgmt_read & ~mgmt_waitrequest;

    // Saturating increments: counters hold at their limit rather than wrap.
    assign poll_inc = (poll_cnt == POLL_LIM) ? poll_cnt : poll_cnt + PW'(1);
    assign to_inc   = (to_cnt == TO_LIM)     ? to_cnt   : to_cnt + TW'(1);
    assign stab_inc = (stab_cnt == STAB_LIM) ? stab_cnt : stab_cnt + SW'(1);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            n_q            <= '0;
            m_q            <= '0;
            c0_q           <= '0;
            poll_cnt       <= '0;
            to_cnt         <= '0;
            stab_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_req) begin
                        n_q            <= cfg_n;
                        m_q            <= cfg_m;
                        c0_q           <= cfg_c0;
                        poll_cnt       <= '0;
                        busy           <= 1'b1;
                        err            <= 1'b0;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= 6'd0;
                        mgmt_writedata <= 32'h1;
                        state          <= S_MODE;
                    end
                end
                // Each write state presents the next transfer on acceptance so
                // write stays high across back-to-back transfers.
                S_MODE: begin
                    if (wr_ack) begin
                        mgmt_address   <= 6'd3;
                        mgmt_writedata <= {14'b0, n_q};
                        state          <= S_WR_N;
                    end
                end
                S_WR_N: begin
                    if (wr_ack) begin
                        mgmt_address   <= 6'd4;
                        mgmt_writedata <= {14'b0, m_q};
                        state          <= S_WR_M;
                    end
                end
                S_WR_M: begin
                    if (wr_ack) begin
                        mgmt_address   <= 6'd5;
                        mgmt_writedata <= {9'b0, 5'd0, c0_q};
                        state          <= S_WR_C;
                    end
                end
                S_WR_C: begin
                    if (wr_ack) begin
                        mgmt_address   <= 6'd2;
                        mgmt_writedata <= 32'h1;
                        state          <= S_START;
                    end
                end
                S_START: begin
                    if (wr_ack) begin
                        mgmt_write     <= 1'b0;
                        mgmt_read      <= 1'b1;
                        mgmt_address   <= 6'd1;
                        mgmt_writedata <= '0;
                        state          <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (rd_ack) begin
                        poll_cnt <= poll_inc;
                        if (mgmt_readdata[0]) begin
                            mgmt_read <= 1'b0;
                            to_cnt    <= '0;
                            stab_cnt  <= '0;
                            state     <= S_LOCK_WAIT;
                        end else if (poll_inc == POLL_LIM) begin
                            mgmt_read <= 1'b0;
                            state     <= S_ERR;
                        end
                    end
                end
                // Stable lock wins over timeout when both land on the same cycle.
                S_LOCK_WAIT: begin
                    to_cnt   <= to_inc;
                    stab_cnt <= lk_s ? stab_inc : '0;
                    if (lk_s && (stab_inc == STAB_LIM)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (to_inc == TO_LIM) begin
                        state <= S_ERR;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    mgmt_write <= 1'b0;
                    mgmt_read  <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpll_reconfig_ctrl.sv
// Scoreboard bench for vpll_reconfig_ctrl: a reconfig-core responder checks each
// completed Avalon transfer against expected transfers queued at request time.
module tb_vpll_reconfig_ctrl;

    localparam int unsigned TB_LOCK_TIMEOUT = 3000;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [17:0] cfg_n;
    logic [17:0] cfg_m;
    logic [17:0] cfg_c0;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    vpll_reconfig_ctrl #(
        .POLL_MAX    (1024),
        .LOCK_TIMEOUT(TB_LOCK_TIMEOUT),
        .LOCK_STABLE (256)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .cfg_req         (cfg_req),
        .cfg_n           (cfg_n),
        .cfg_m           (cfg_m),
        .cfg_c0          (cfg_c0),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_read       (mgmt_read),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_readdata   (mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked)
    );

    always #10 refclk = ~refclk;

    typedef struct packed {
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int unsigned stall_len = 0;
    logic [31:0] status_val = '0;
    int          read_count = 0;
    int          last_read_cyc = 0;
    int          first_wr_cyc = 0;
    int          last_wr_cyc = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reconfig-core responder: stalls each transfer stall_len cycles, then
    // scores the completed transfer against the queue.
    initial begin : responder
        int unsigned stall_cnt = 0;
        int unsigned hold_cnt = 0;
        logic [5:0]  held_addr = '0;
        logic [31:0] held_data = '0;
        xfer_t       e;
        mgmt_waitrequest = 1'b0;
        mgmt_readdata    = '0;
        forever begin
            @(negedge refclk);
            if (rst || !(mgmt_write || mgmt_read)) begin
                mgmt_waitrequest = 1'b0;
                stall_cnt = 0;
                hold_cnt  = 0;
            end else begin
                if (stall_cnt < stall_len) begin
                    mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
                mgmt_readdata = status_val;
                if (hold_cnt > 0) begin
                    check("hold_addr", mgmt_address, held_addr);
                    check("hold_data", mgmt_writedata, held_data);
                end
                held_addr = mgmt_address;
                held_data = mgmt_writedata;
                hold_cnt++;
                if (!mgmt_waitrequest) begin
                    check("hold_cycles", hold_cnt, stall_len + 1);
                    hold_cnt = 0;
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected", {mgmt_read, mgmt_address}, 7'h7f);
                    end else begin
                        e = sb_q.pop_front();
                        check("xfer_kind", mgmt_read, e.rd);
                        check("xfer_addr", mgmt_address, e.addr);
                        if (!e.rd) check("xfer_data", mgmt_writedata, e.data);
                    end
                    if (mgmt_read) begin
                        read_count++;
                        last_read_cyc = cyc;
                    end else begin
                        if (mgmt_address == 6'd0) first_wr_cyc = cyc;
                        last_wr_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic request(input logic [17:0] n, input logic [17:0] m,
                           input logic [17:0] c0, input int nreads);
        sb_q.push_back({1'b0, 6'd0, 32'h1});
        sb_q.push_back({1'b0, 6'd3, {14'b0, n}});
        sb_q.push_back({1'b0, 6'd4, {14'b0, m}});
        sb_q.push_back({1'b0, 6'd5, {14'b0, c0}});
        sb_q.push_back({1'b0, 6'd2, 32'h1});
        for (int i = 0; i < nreads; i++) sb_q.push_back({1'b1, 6'd1, 32'h0});
        @(negedge refclk);
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
        check("busy_after_req", busy, 1'b1);
        check("err_after_req", err, 1'b0);
    endtask

    // Waits (bounded) for done or err; on done, pokes a request into the DONE cycle.
    task automatic wait_end(input int limit, output logic got_done, output logic got_err,
                            output int end_cyc);
        got_done = 1'b0; got_err = 1'b0; end_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge refclk);
            if (done || err) begin
                got_done = done; got_err = err; end_cyc = cyc;
                break;
            end
        end
        if (end_cyc < 0) check("wait_bound_expired", 1'b1, 1'b0);
        if (got_done) begin
            cfg_n = 18'h3ffff; cfg_req = 1'b1;
            @(negedge refclk);
            cfg_req = 1'b0;
            check("done_one_cycle", done, 1'b0);
            check("busy_after_done", busy, 1'b0);
        end
    endtask

    initial begin : main
        logic got_done;
        logic got_err;
        int   end_cyc;
        int   any_act;
        int   reads0;
        int   restore_cyc;
        rst = 1'b1; cfg_req = 1'b0; cfg_n = '0; cfg_m = '0; cfg_c0 = '0; pll_locked = 1'b0;

        repeat (3) @(negedge refclk);
        check("reset_outs", {busy, done, err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, 41'h0);
        rst = 1'b0;
        any_act = 0;
        repeat (100) begin
            @(negedge refclk);
            if (busy || done || err || mgmt_write || mgmt_read) any_act++;
        end
        check("idle_quiet", any_act, 0);

        // Nominal retune, no stalls, status done on first read, lock steady.
        pll_locked = 1'b1; status_val = 32'h1; stall_len = 0;
        repeat (4) @(negedge refclk);
        request(18'h00101, 18'h01B1B, 18'h00303, 1);
        wait_end(600, got_done, got_err, end_cyc);
        check("nom_done", {got_done, got_err}, 2'b10);
        check("nom_write_span", last_wr_cyc - first_wr_cyc, 4);
        check("nom_read_gap", last_read_cyc - last_wr_cyc, 1);
        check("nom_done_lat", end_cyc - last_read_cyc, 257);
        repeat (10) @(negedge refclk);
        check("ignored_req_busy", busy, 1'b0);

        // Every transfer stalled 3 cycles.
        stall_len = 3;
        request(18'h20202, 18'h10A0B, 18'h00404, 1);
        wait_end(800, got_done, got_err, end_cyc);
        check("stall_done", {got_done, got_err}, 2'b10);
        check("stall_write_span", last_wr_cyc - first_wr_cyc, 16);
        check("stall_read_gap", last_read_cyc - last_wr_cyc, 4);
        check("stall_done_lat", end_cyc - last_read_cyc, 257);
        stall_len = 0;

        // Lock glitch mid-count; a request during LOCK_WAIT must be ignored.
        reads0 = read_count;
        request(18'h00A05, 18'h00C06, 18'h00207, 1);
        for (int i = 0; i < 50 && read_count == reads0; i++) @(negedge refclk);
        check("glitch_read_seen", read_count - reads0, 1);
        repeat (100) @(negedge refclk);
        cfg_n = 18'h12345; cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
        repeat (99) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        restore_cyc = cyc;
        wait_end(600, got_done, got_err, end_cyc);
        check("glitch_done", {got_done, got_err}, 2'b10);
        check("glitch_done_lat", end_cyc - restore_cyc, 258);

        // Status never completes: exactly 1024 reads then err.
        status_val = 32'h0;
        reads0 = read_count;
        request(18'h00111, 18'h00222, 18'h00333, 1024);
        wait_end(2000, got_done, got_err, end_cyc);
        check("poll_err", {got_done, got_err}, 2'b01);
        check("poll_busy_low", busy, 1'b0);
        check("poll_read_count", read_count - reads0, 1024);
        repeat (5) @(negedge refclk);
        check("err_sticky", err, 1'b1);

        // Lock never seen: timeout after TB_LOCK_TIMEOUT cycles (request clears err).
        status_val = 32'h1; pll_locked = 1'b0;
        request(18'h00444, 18'h00555, 18'h00666, 1);
        wait_end(TB_LOCK_TIMEOUT + 200, got_done, got_err, end_cyc);
        check("timeout_err", {got_done, got_err}, 2'b01);
        check("timeout_lat", end_cyc - last_read_cyc, TB_LOCK_TIMEOUT + 2);

        // Reset asserted during WR_M, then a fresh request restarts from MODE.
        pll_locked = 1'b1; stall_len = 3;
        request(18'h00777, 18'h00888, 18'h00999, 1);
        for (int i = 0; i < 40 && !(mgmt_write && mgmt_address == 6'd4); i++) @(negedge refclk);
        check("wrm_reached", {mgmt_write, mgmt_address}, 7'h44);
        #2 rst = 1'b1;
        #1;
        check("rst_strobes", {mgmt_write, mgmt_read, busy}, 3'b000);
        sb_q.delete();
        @(negedge refclk);
        rst = 1'b0;
        request(18'h00ABC, 18'h00DEF, 18'h00123, 1);
        wait_end(800, got_done, got_err, end_cyc);
        check("rst_restart_done", {got_done, got_err}, 2'b10);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vpll_reconfig_ctrl.md
Name: vpll_reconfig_ctrl

Overview:
- Sequences run-time retuning of the video PLL through an Altera PLL reconfiguration core (Avalon-MM management port, polling mode).
- On a request it latches new N/M/C0 counter words and writes them in a fixed order. It then starts the reconfiguration, polls for completion and waits for a stable PLL lock.
- Sits between the video-mode selection logic and the PLL reconfig core, and runs on the PLL reference clock.

Parameters:
- POLL_MAX, 1024: maximum status reads before declaring a timeout.
- LOCK_TIMEOUT, 1000000: cycles allowed for synchronized lock to be seen high after reconfig done.
- LOCK_STABLE, 256: consecutive high cycles of synchronized lock required before completion.

Ports:
- refclk in 1: controller clock (50 MHz reference domain).
- rst in 1: asynchronous active-high reset.
- cfg_req in 1: single-cycle request to reconfigure.
- cfg_n in 18: N counter word {bypass, odd, hi[7:0], lo[7:0]}.
- cfg_m in 18: M counter word, same encoding.
- cfg_c0 in 18: C0 word, same encoding; [22:18] of the written data carries counter select 0.
- busy out 1: high from accepted request until done/err.
- done out 1: one-cycle pulse on successful completion.
- err out 1: sticky timeout flag; cleared by the next accepted request.
- mgmt_address out 6: reconfig core address.
- mgmt_write out 1: write strobe.
- mgmt_read out 1: read strobe.
- mgmt_writedata out 32: write data.
- mgmt_readdata in 32: read data.
- mgmt_waitrequest in 1: core stall.
- pll_locked in 1: asynchronous PLL lock.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, lock synchronizer 0.
- pll_locked passes through a 2-flop synchronizer (lk_s) before any use.
- cfg_req is accepted only in IDLE and is ignored otherwise. On acceptance:
  - cfg_n, cfg_m and cfg_c0 are latched.
  - busy=1 and err=0 from the next cycle.
- Avalon write rule: address, writedata and write are held stable until a cycle with write=1 and waitrequest=0. In that cycle the transfer completes, and write drops the following cycle when the next state is not a write.
- Avalon read rule: read is held until waitrequest=0. readdata is sampled in that same cycle.
- Write sequence (state: address, writedata):
  - MODE: addr 0, 32'h1 (polling mode).
  - WR_N: addr 3, {14'b0, n}.
  - WR_M: addr 4, {14'b0, m}.
  - WR_C: addr 5, {9'b0, 5'd0, c0}.
  - START: addr 2, 32'h1.
- Back-to-back writes are allowed: when waitrequest stays 0, the five writes complete in 5 consecutive cycles with write held high throughout.
- POLL: issue a read of addr 1 and increment poll_cnt on each completed read.
  - readdata[0]=1 → go to LOCK_WAIT and clear the lock counters.
  - readdata[0]=0 and poll_cnt==POLL_MAX → go to ERR.
  - Otherwise issue another read on the next cycle.
- LOCK_WAIT: increment to_cnt every cycle.
  - stab_cnt increments while lk_s=1 and resets to 0 when lk_s=0.
  - stab_cnt reaching LOCK_STABLE → go to DONE. This has priority over timeout in the same cycle.
  - to_cnt reaching LOCK_TIMEOUT → go to ERR.
- DONE: done=1 for one cycle, busy=0 in the next cycle, return to IDLE.
- ERR: err=1 (sticky), busy=0, return to IDLE. No done pulse.
- Counters are sized with $clog2 of their limit plus 1 and saturate; they never wrap.
- rst asserted mid-transaction: strobes drop immediately (async) and state returns to IDLE. The reconfig core is not told to abort, so software must re-request.
- A cfg_req arriving in the same cycle as DONE or ERR is ignored; only IDLE accepts.

Test Plan:
- Reset then idle, waitrequest=0: all outputs 0 and no mgmt strobes for 100 cycles.
- Request with n=18'h00101, m=18'h01B1B, c0=18'h00303, waitrequest=0, status returns 1 on the first read, locked high throughout → writes (0,1),(3,00101),(4,01B1B),(5,00303),(2,1) in 5 consecutive cycles, then one read of addr 1, then done pulses after the synchronizer plus 256 stable cycles; busy falls the cycle after done.
- waitrequest held high 3 cycles on every transfer → each strobe and its address/data are held 4 cycles and the write order is unchanged.
- Status never sets bit 0 → exactly 1024 reads of addr 1, then err=1 and busy=0 with no done; a new request clears err.
- Lock glitches low once at stable count 200 → stab_cnt restarts and done occurs 256 cycles after lock returns high.
- rst pulsed during WR_M → mgmt_write=0 immediately and state IDLE; a following request restarts from MODE.
